// File: rtl/register_pkg.sv
// Shared definitions for the general-purpose storage register and the
// blocks that instantiate it.
package register_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] reg_word_t;

endpackage : register_pkg

// File: rtl/register.sv
// Clock-enabled holding register with asynchronous active-low clear.
// The output is taken straight from the storage flops.
module register
    import register_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // NOTE: out_d defaults to the held value before the enable test, so a
    // disabled cycle never leaves the next-state undriven (no latch).
    always_comb begin
        out_d = out_q;
        if (enable) begin
            out_d = data;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // its inputs as they were before the edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            out_q <= RESET_VALUE;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : register

// File: tb/tb_register.sv
// Self-checking bench for the holding register: directed scenarios followed
// by randomized traffic compared against a cycle-level behavioural model.
module tb_register;
    import register_pkg::*;

    localparam reg_word_t RST_VAL = '0;

    logic      clk  = 1'b0;
    logic      rst_ = 1'b1;
    logic      enable;
    reg_word_t data;
    reg_word_t out;

    int n_checks = 0;
    int n_fail   = 0;

    // Value the register must present at the next falling edge.
    reg_word_t exp_q;

    register #(
        .WIDTH       (DEFAULT_WIDTH),
        .RESET_VALUE (RST_VAL)
    ) u_dut (
        .clk    (clk),
        .rst_   (rst_),
        .enable (enable),
        .data   (data),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input reg_word_t act, input reg_word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Called just after a falling edge: drive one cycle of stimulus, predict
    // the result from the register's rules, and check at the next falling edge.
    task automatic cycle(input string tag, input logic r, input logic en, input reg_word_t d);
        rst_   = r;
        enable = en;
        data   = d;
        if (!r)
            exp_q = RST_VAL;
        else if (en)
            exp_q = d;
        @(negedge clk);
        check(tag, out, exp_q);
    endtask

    initial begin
        enable = 1'bx;
        data   = 'x;

        // 1. Reset clears immediately, mid-cycle, with X on the inputs.
        #3 rst_ = 1'b0;
        #1 check("async_clear_initial", out, RST_VAL);
        @(negedge clk);
        cycle("reset_x_inputs", 1'b0, 1'bx, 'x);
        cycle("reset_hold", 1'b0, 1'bx, 'x);

        // 2. Hold after release with enable low and X data.
        cycle("hold_after_reset", 1'b1, 1'b0, 'x);
        cycle("hold_after_reset2", 1'b1, 1'b0, 'x);

        // 3. Load then hold.
        cycle("load_aa", 1'b1, 1'b1, 8'hAA);
        cycle("hold_aa", 1'b1, 1'b0, 8'h55);

        // 4. Asynchronous re-reset mid-operation, release with enable low.
        @(posedge clk);
        #2 rst_ = 1'b0;
        #1 check("async_clear_midop", out, RST_VAL);
        exp_q = RST_VAL;
        @(negedge clk);
        check("reset_held_midop", out, RST_VAL);
        cycle("release_no_load", 1'b1, 1'b0, 8'hAA);

        // 5. Reload and hold.
        cycle("load_55", 1'b1, 1'b1, 8'h55);
        cycle("hold_55", 1'b1, 1'b0, 8'hAA);

        // 6. Reset beats a pending load, then load on the first edge after release.
        cycle("reset_beats_load", 1'b0, 1'b1, 8'hFF);
        cycle("load_after_release", 1'b1, 1'b1, 8'h3C);

        // Randomized traffic with occasional resets and X data while disabled.
        for (int i = 0; i < 400; i++) begin
            logic      r;
            logic      en;
            reg_word_t d;
            r  = ($urandom_range(0, 15) != 0);
            en = $urandom_range(0, 1) == 1;
            d  = reg_word_t'($urandom);
            if (!en && $urandom_range(0, 3) == 0)
                d = 'x;
            if (!r)
                en = 1'bx;
            cycle("random", r, en, d);
        end

        // Asynchronous clear while a known non-reset value is held.
        cycle("preload_c3", 1'b1, 1'b1, 8'hC3);
        #7 rst_ = 1'b0;
        #1 check("async_clear_random", out, RST_VAL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_register
